// File: rtl/vdp_timing_gen.sv
// ---------------------------------------------------------------------------
// vdp_timing_gen
//   Video timing generator for the VDP: dot/line counters, dot phases,
//   H/V sync, blanking windows and the interlace field flag for NTSC/PAL.
//   Mode and adjust inputs are shadowed at each frame boundary so that
//   register-file writes never disturb a frame in progress.
//
// Ports
//   clk             in   system clock
//   reset_n         in   synchronous reset, active low
//   enable          in   clock qualifier; state advances only when 1
//   pal_mode        in   1 = PAL line count (shadowed)
//   interlace_mode  in   1 = interlaced (shadowed)
//   adj_h           in   signed horizontal adjust, 4-clock units (shadowed)
//   adj_v           in   signed vertical adjust, lines (shadowed)
//   h_cnt           out  clock position in line
//   v_cnt           out  line in field
//   dot_state       out  Gray-coded phase of h_cnt[1:0]
//   eight_dot_state out  h_cnt[4:2]
//   field           out  0 = even field, 1 = odd field
//   hsync           out  active-high horizontal sync
//   vsync_n         out  active-low vertical sync
//   h_blank         out  1 outside horizontal active window
//   v_blank         out  1 outside vertical active window
//   frame_start     out  one enabled-cycle pulse at (0,0)
// ---------------------------------------------------------------------------
module vdp_timing_gen #(
    parameter int H_TOTAL        = 1368,
    parameter int H_SYNC_W       = 100,
    parameter int H_ACTIVE_START = 256,
    parameter int H_ACTIVE_W     = 1024,
    parameter int NTSC_LINES     = 262,
    parameter int PAL_LINES      = 313,
    parameter int V_SYNC_LINES   = 3,
    parameter int V_ACTIVE_START = 27,
    parameter int V_ACTIVE_LINES = 212,
    localparam int HW            = $clog2(H_TOTAL),
    localparam int VW            = $clog2(PAL_LINES + 2)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          pal_mode,
    input  logic          interlace_mode,
    input  logic [3:0]    adj_h,
    input  logic [3:0]    adj_v,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic [1:0]    dot_state,
    output logic [2:0]    eight_dot_state,
    output logic          field,
    output logic          hsync,
    output logic          vsync_n,
    output logic          h_blank,
    output logic          v_blank,
    output logic          frame_start
);

    // Two spare bits keep window start/end sums free of overflow for any
    // legal parameter set, including a negative adjust.
    localparam int SHW = HW + 2;
    localparam int SVW = VW + 2;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_HALF = HW'(H_TOTAL / 2);

    logic       r_pal_s;
    logic       r_int_s;
    logic [3:0] r_adjh_s;
    logic [3:0] r_adjv_s;
    logic       r_first;

    logic [VW-1:0] w_lines;
    logic          w_h_wrap;
    logic          w_frame_end;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic          w_pal_nxt;
    logic          w_int_nxt;
    logic [3:0]    w_adjh_nxt;
    logic [3:0]    w_adjv_nxt;
    logic          w_field_nxt;

    logic signed [SHW-1:0] w_adjh_sx;
    logic signed [SVW-1:0] w_adjv_sx;
    logic signed [SHW-1:0] w_hs;
    logic signed [SHW-1:0] w_hpos;
    logic signed [SVW-1:0] w_vs;
    logic signed [SVW-1:0] w_vpos;
    logic                  w_h_act;
    logic                  w_v_act;
    logic                  w_h_ge_half;
    logic                  w_vs_low;

    // Lines in the frame currently being scanned; the odd interlaced field
    // carries one extra line.
    assign w_lines     = (r_pal_s ? VW'(PAL_LINES) : VW'(NTSC_LINES))
                       + VW'(r_int_s & field);
    assign w_h_wrap    = (h_cnt == H_LAST);
    assign w_frame_end = w_h_wrap && (v_cnt >= w_lines - VW'(1));

    assign w_h_nxt = w_h_wrap ? '0 : h_cnt + HW'(1);
    assign w_v_nxt = w_frame_end ? '0 : (w_h_wrap ? v_cnt + VW'(1) : v_cnt);

    assign w_pal_nxt  = w_frame_end ? pal_mode       : r_pal_s;
    assign w_int_nxt  = w_frame_end ? interlace_mode : r_int_s;
    assign w_adjh_nxt = w_frame_end ? adj_h          : r_adjh_s;
    assign w_adjv_nxt = w_frame_end ? adj_v          : r_adjv_s;

    // The first boundary after reset always starts an even field.
    assign w_field_nxt = w_frame_end ? (!r_first && interlace_mode && !field) : field;

    // Window decode works on the next-state values so the registered
    // outputs line up with the registered counters.
    assign w_adjh_sx = {{(SHW-4){w_adjh_nxt[3]}}, w_adjh_nxt};
    assign w_adjv_sx = {{(SVW-4){w_adjv_nxt[3]}}, w_adjv_nxt};
    assign w_hs      = SHW'(H_ACTIVE_START) + (w_adjh_sx <<< 2);
    assign w_vs      = SVW'(V_ACTIVE_START) + w_adjv_sx;
    assign w_hpos    = $signed({2'b00, w_h_nxt});
    assign w_vpos    = $signed({2'b00, w_v_nxt});
    assign w_h_act   = (w_hpos >= w_hs) && (w_hpos < w_hs + SHW'(H_ACTIVE_W));
    assign w_v_act   = (w_vpos >= w_vs) && (w_vpos < w_vs + SVW'(V_ACTIVE_LINES));

    // Odd interlaced field: vsync spans half a line later, from mid-line 0
    // to mid-line V_SYNC_LINES.
    assign w_h_ge_half = (w_h_nxt >= H_HALF);
    always_comb begin
        w_vs_low = 1'b0;
        if (w_int_nxt && w_field_nxt) begin
            if (w_v_nxt == '0)
                w_vs_low = w_h_ge_half;
            else if (w_v_nxt < VW'(V_SYNC_LINES))
                w_vs_low = 1'b1;
            else if (w_v_nxt == VW'(V_SYNC_LINES))
                w_vs_low = !w_h_ge_half;
        end else begin
            w_vs_low = (w_v_nxt < VW'(V_SYNC_LINES));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_cnt           <= H_LAST;
            v_cnt           <= VW'(NTSC_LINES - 1);
            dot_state       <= {H_LAST[1], H_LAST[1] ^ H_LAST[0]};
            eight_dot_state <= H_LAST[4:2];
            field           <= 1'b0;
            hsync           <= 1'b0;
            vsync_n         <= 1'b1;
            h_blank         <= 1'b1;
            v_blank         <= 1'b1;
            frame_start     <= 1'b0;
            r_pal_s         <= 1'b0;
            r_int_s         <= 1'b0;
            r_adjh_s        <= 4'd0;
            r_adjv_s        <= 4'd0;
            r_first         <= 1'b1;
        end else if (enable) begin
            h_cnt           <= w_h_nxt;
            v_cnt           <= w_v_nxt;
            dot_state       <= {w_h_nxt[1], w_h_nxt[1] ^ w_h_nxt[0]};
            eight_dot_state <= w_h_nxt[4:2];
            field           <= w_field_nxt;
            hsync           <= (w_h_nxt < HW'(H_SYNC_W));
            vsync_n         <= !w_vs_low;
            h_blank         <= !w_h_act;
            v_blank         <= !w_v_act;
            frame_start     <= w_frame_end;
            r_pal_s         <= w_pal_nxt;
            r_int_s         <= w_int_nxt;
            r_adjh_s        <= w_adjh_nxt;
            r_adjv_s        <= w_adjv_nxt;
            if (w_frame_end)
                r_first <= 1'b0;
        end else begin
            // A held clock must not stretch the frame_start pulse.
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vdp_timing_gen.sv
module tb_vdp_timing_gen;

    // Scaled-down timing so several full frames fit in a short run.
    localparam int H   = 128;
    localparam int HSW = 10;
    localparam int HAS = 40;
    localparam int HAW = 56;
    localparam int NL  = 20;
    localparam int PL  = 25;
    localparam int VSL = 3;
    localparam int VAS = 9;
    localparam int VAL = 8;
    localparam int HW  = $clog2(H);
    localparam int VW  = $clog2(PL + 2);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          pal_mode;
    logic          interlace_mode;
    logic [3:0]    adj_h;
    logic [3:0]    adj_v;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [1:0]    dot_state;
    logic [2:0]    eight_dot_state;
    logic          field;
    logic          hsync;
    logic          vsync_n;
    logic          h_blank;
    logic          v_blank;
    logic          frame_start;

    vdp_timing_gen #(
        .H_TOTAL(H), .H_SYNC_W(HSW), .H_ACTIVE_START(HAS), .H_ACTIVE_W(HAW),
        .NTSC_LINES(NL), .PAL_LINES(PL), .V_SYNC_LINES(VSL),
        .V_ACTIVE_START(VAS), .V_ACTIVE_LINES(VAL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pal_mode(pal_mode),
        .interlace_mode(interlace_mode), .adj_h(adj_h), .adj_v(adj_v),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .dot_state(dot_state),
        .eight_dot_state(eight_dot_state), .field(field), .hsync(hsync),
        .vsync_n(vsync_n), .h_blank(h_blank), .v_blank(v_blank),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: position is a cycle index t inside the current frame.
    int m_t, m_lines, m_adjh, m_adjv;
    bit m_int, m_field, m_first, m_fs, m_rstv;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            m_valid = 1'b1; m_rstv = 1'b1; m_t = NL * H - 1; m_lines = NL;
            m_int = 1'b0; m_adjh = 0; m_adjv = 0;
            m_field = 1'b0; m_first = 1'b1; m_fs = 1'b0;
        end else if (m_valid && enable) begin
            m_rstv = 1'b0;
            m_fs   = 1'b0;
            m_t++;
            if (m_t >= m_lines * H) begin
                m_t     = 0;
                m_fs    = 1'b1;
                m_int   = interlace_mode;
                m_adjh  = int'($signed(adj_h));
                m_adjv  = int'($signed(adj_v));
                m_field = m_first ? 1'b0 : (m_int ? !m_field : 1'b0);
                m_first = 1'b0;
                m_lines = (pal_mode ? PL : NL) + ((m_int && m_field) ? 1 : 0);
            end
        end else begin
            m_fs = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            int h, v, hs, vs, e_dot, e_hs, e_vsn, e_hb, e_vb;
            h = m_t % H;
            v = m_t / H;
            case (h % 4)
                0: e_dot = 0;
                1: e_dot = 1;
                2: e_dot = 3;
                default: e_dot = 2;
            endcase
            hs = HAS + 4 * m_adjh;
            vs = VAS + m_adjv;
            if (m_rstv) begin
                e_hs = 0; e_vsn = 1; e_hb = 1; e_vb = 1;
            end else begin
                e_hs = (h < HSW) ? 1 : 0;
                e_hb = (h >= hs && h < hs + HAW) ? 0 : 1;
                e_vb = (v >= vs && v < vs + VAL) ? 0 : 1;
                if (m_int && m_field)
                    e_vsn = (m_t >= H / 2 && m_t < VSL * H + H / 2) ? 0 : 1;
                else
                    e_vsn = (v < VSL) ? 0 : 1;
            end
            chk("h_cnt", int'(h_cnt), h);
            chk("v_cnt", int'(v_cnt), v);
            chk("dot_state", int'(dot_state), e_dot);
            chk("eight_dot_state", int'(eight_dot_state), (h / 4) % 8);
            chk("field", int'(field), int'(m_field));
            chk("hsync", int'(hsync), e_hs);
            chk("vsync_n", int'(vsync_n), e_vsn);
            chk("h_blank", int'(h_blank), e_hb);
            chk("v_blank", int'(v_blank), e_vb);
            chk("frame_start", int'(frame_start), int'(m_fs));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic goto_pos(input int v, input int h);
        bit found = 1'b0;
        for (int k = 0; k < 8000 && !found; k++) begin
            @(negedge clk);
            if (int'(v_cnt) == v && int'(h_cnt) == h) found = 1'b1;
        end
        if (!found) chk("goto_timeout", 0, 1);
    endtask

    task automatic wait_fs(output int c);
        bit found = 1'b0;
        c = -1;
        for (int k = 0; k < 8000 && !found; k++) begin
            @(negedge clk);
            if (frame_start) begin found = 1'b1; c = cyc; end
        end
        if (!found) chk("frame_start_timeout", 0, 1);
    endtask

    task automatic do_reset(input bit pal, input bit intl);
        @(negedge clk);
        reset_n = 1'b0; enable = 1'b0;
        pal_mode = pal; interlace_mode = intl; adj_h = 4'd0; adj_v = 4'd0;
        step(2);
        reset_n = 1'b1; enable = 1'b1;
    endtask

    initial begin
        int c0, c1, c2, c3, c4;
        reset_n = 1'b0; enable = 1'b0; pal_mode = 1'b0; interlace_mode = 1'b0;
        adj_h = 4'd0; adj_v = 4'd0;

        // Reset values, NTSC progressive
        step(3);
        chk("rst_h_cnt", int'(h_cnt), 127);
        chk("rst_v_cnt", int'(v_cnt), 19);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_vsync_n", int'(vsync_n), 1);
        chk("rst_h_blank", int'(h_blank), 1);
        chk("rst_hsync", int'(hsync), 0);
        reset_n = 1'b1; enable = 1'b1;
        step(1);
        chk("first_fs", int'(frame_start), 1);
        chk("first_h", int'(h_cnt), 0);
        chk("first_v", int'(v_cnt), 0);
        c0 = cyc;
        goto_pos(2, 127);
        chk("ntsc_vsync_low_l2", int'(vsync_n), 0);
        step(1);
        chk("ntsc_vsync_high_l3", int'(vsync_n), 1);
        goto_pos(4, 9);
        chk("hsync_last", int'(hsync), 1);
        step(1);
        chk("hsync_off", int'(hsync), 0);
        wait_fs(c1);
        chk("ntsc_period", c1 - c0, 2560);
        chk("ntsc_field", int'(field), 0);

        // PAL from reset
        do_reset(1'b1, 1'b0);
        step(1);
        c0 = cyc;
        goto_pos(24, 127);
        chk("pal_last_line_no_fs", int'(frame_start), 0);
        step(1);
        chk("pal_wrap_fs", int'(frame_start), 1);
        chk("pal_period", cyc - c0, 3200);

        // NTSC interlace
        do_reset(1'b0, 1'b1);
        step(1);
        c0 = cyc;
        chk("int_field0", int'(field), 0);
        wait_fs(c1);
        chk("int_period_even", c1 - c0, 2560);
        chk("int_field1", int'(field), 1);
        goto_pos(0, 63);
        chk("odd_vsync_pre_half", int'(vsync_n), 1);
        step(1);
        chk("odd_vsync_fall_h", int'(h_cnt), 64);
        chk("odd_vsync_fall", int'(vsync_n), 0);
        goto_pos(3, 63);
        chk("odd_vsync_still_low", int'(vsync_n), 0);
        step(1);
        chk("odd_vsync_rise", int'(vsync_n), 1);
        wait_fs(c2);
        chk("int_period_odd", c2 - c1, 2688);
        chk("int_field_back0", int'(field), 0);

        // Enable gap of 100 cycles
        do_reset(1'b0, 1'b0);
        step(1);
        c0 = cyc;
        goto_pos(1, 50);
        enable = 1'b0;
        step(100);
        chk("frozen_h", int'(h_cnt), 50);
        chk("frozen_v", int'(v_cnt), 1);
        enable = 1'b1;
        wait_fs(c1);
        chk("gap_period", c1 - c0, 2660);

        // Mid-frame mode change takes effect at the next boundary
        goto_pos(10, 0);
        pal_mode = 1'b1; adj_h = 4'h8;
        wait_fs(c2);
        chk("shadow_period_ntsc", c2 - c1, 2560);
        goto_pos(1, 7);
        chk("adjh_blank_pre", int'(h_blank), 1);
        step(1);
        chk("adjh_blank_fall", int'(h_blank), 0);
        wait_fs(c3);
        chk("shadow_period_pal", c3 - c2, 3200);

        // Reset mid-frame, then adj_v=7 applies after release
        adj_v = 4'd7;
        wait_fs(c4);
        goto_pos(5, 70);
        reset_n = 1'b0;
        step(1);
        chk("midrst_h", int'(h_cnt), 127);
        chk("midrst_v", int'(v_cnt), 19);
        chk("midrst_fs", int'(frame_start), 0);
        chk("midrst_v_blank", int'(v_blank), 1);
        reset_n = 1'b1; pal_mode = 1'b0; adj_h = 4'd0;
        step(1);
        chk("midrst_first_fs", int'(frame_start), 1);
        goto_pos(15, 127);
        chk("adjv_blank_pre", int'(v_blank), 1);
        step(1);
        chk("adjv_blank_fall", int'(v_blank), 0);
        chk("adjv_blank_line", int'(v_cnt), 16);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
